// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// MEM-stage to data-memory request/response bundle.
interface dmem_if;
  import dmem_pkg::*;

  logic             cs;
  logic [LANES-1:0] web;
  logic [31:0]      addr;
  logic [31:0]      din;
  logic [31:0]      dout;
  logic             stall;
  logic             err;

  modport master (
    output cs, web, addr, din,
    input  dout, stall, err
  );

  modport slave (
    input  cs, web, addr, din,
    output dout, stall, err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage with per-lane write mask and registered read port.
module dmem_array import dmem_pkg::*; #(
  parameter int unsigned Depth = 16384,
  parameter int unsigned AddrW = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [LANES-1:0] wmask,
  input  logic [AddrW-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [Depth];
  logic [31:0] rdata_q;

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (req) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (req && (wmask == '0)) begin
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: IDLE/WAIT/DONE handshake with stall, range check
// and read-data alignment in front of a single-port array.
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int unsigned AddrW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_W-1:0] WaitLoad =
      (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  state_e           state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [LANES-1:0] web_q;
  logic [31:0]      din_q;
  logic             err_q;
  logic [1:0]       shift_q;
  logic             zero_q;

  logic [31:0]      req_addr;
  logic [LANES-1:0] req_web;
  logic [31:0]      req_din;
  logic             in_range;
  logic             go_done;
  logic             arr_req;
  logic [31:0]      arr_rdata;

  // With no wait states the access happens on the capture edge, so use the live request.
  always_comb begin
    req_addr = addr_q;
    req_web  = web_q;
    req_din  = din_q;
    if (state_q == StIdle) begin
      req_addr = bus.addr;
      req_web  = bus.web;
      req_din  = bus.din;
    end
  end

  assign in_range = (req_addr >> 2) < DEPTH_WORDS;
  assign go_done  = ((state_q == StIdle) && bus.cs && (WAIT_CYCLES == 0)) ||
                    ((state_q == StWait) && (cnt_q == '0));
  assign arr_req  = go_done && in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      web_q   <= '1;
      din_q   <= '0;
      err_q   <= 1'b0;
      shift_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cs) begin
            addr_q <= bus.addr;
            web_q  <= bus.web;
            din_q  <= bus.din;
            if (WAIT_CYCLES == 0) begin
              state_q <= StDone;
            end else begin
              cnt_q   <= WaitLoad;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - WAIT_W'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // Output view only changes on reads or out-of-range accesses; writes leave dout alone.
      if (go_done) begin
        err_q <= !in_range;
        if (!in_range) begin
          zero_q <= 1'b1;
        end else if (req_web == '1) begin
          zero_q  <= 1'b0;
          shift_q <= req_addr[1:0];
        end
      end
    end
  end

  dmem_array #(
    .Depth (DEPTH_WORDS),
    .AddrW (AddrW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .req   (arr_req),
    .wmask (~req_web),
    .idx   (req_addr[AddrW+1:2]),
    .wdata (req_din),
    .rdata (arr_rdata)
  );

  assign bus.stall = ((state_q == StIdle) && bus.cs) || (state_q == StWait);
  assign bus.err   = err_q;
  assign bus.dout  = zero_q ? '0 : (arr_rdata >> {shift_q, 3'b000});

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (WAIT_CYCLES 1, 0, 3; 16 words each) driven in turn.
module tb_dmem_responder;

  logic clk;
  logic rst_d   [3];
  logic cs_d    [3];
  logic [3:0]  web_d  [3];
  logic [31:0] addr_d [3];
  logic [31:0] din_d  [3];
  logic [31:0] dout_s [3];
  logic stall_s [3];
  logic err_s   [3];

  int n_checks = 0;
  int n_err    = 0;

  dmem_if bus0 ();
  dmem_if bus1 ();
  dmem_if bus2 ();

  assign bus0.cs = cs_d[0];  assign bus0.web = web_d[0];
  assign bus0.addr = addr_d[0];  assign bus0.din = din_d[0];
  assign dout_s[0] = bus0.dout;  assign stall_s[0] = bus0.stall;  assign err_s[0] = bus0.err;

  assign bus1.cs = cs_d[1];  assign bus1.web = web_d[1];
  assign bus1.addr = addr_d[1];  assign bus1.din = din_d[1];
  assign dout_s[1] = bus1.dout;  assign stall_s[1] = bus1.stall;  assign err_s[1] = bus1.err;

  assign bus2.cs = cs_d[2];  assign bus2.web = web_d[2];
  assign bus2.addr = addr_d[2];  assign bus2.din = din_d[2];
  assign dout_s[2] = bus2.dout;  assign stall_s[2] = bus2.stall;  assign err_s[2] = bus2.err;

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(1)) dut_w1 (
    .clk (clk), .rst (rst_d[0]), .bus (bus0.slave)
  );
  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut_w0 (
    .clk (clk), .rst (rst_d[1]), .bus (bus1.slave)
  );
  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) dut_w3 (
    .clk (clk), .rst (rst_d[2]), .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE just after a rising edge; returns in IDLE just after a rising edge.
  task automatic access(input int d, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input int wc, input bit drop, input string tag,
                        output logic [31:0] rd, output logic er);
    cs_d[d] = 1'b1; web_d[d] = w; addr_d[d] = a; din_d[d] = wd;
    for (int c = 0; c <= wc; c++) begin
      @(negedge clk);
      check({tag, " stall"}, 32'(stall_s[d]), 32'd1);
      @(posedge clk); #1;
      if (drop || c == wc) cs_d[d] = 1'b0;
      if (drop) addr_d[d] = 32'hFFFF_FFFC;
    end
    @(negedge clk);
    check({tag, " done_stall"}, 32'(stall_s[d]), 32'd0);
    rd = dout_s[d];
    er = err_s[d];
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] exp_v [3];

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_d[d] = 1'b1; cs_d[d] = 1'b0; web_d[d] = 4'hF; addr_d[d] = '0; din_d[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst dout", dout_s[d], 32'h0);
      check("rst err", 32'(err_s[d]), 32'd0);
      check("rst stall", 32'(stall_s[d]), 32'd0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) rst_d[d] = 1'b0;

    // WAIT_CYCLES = 1
    access(0, 4'b0000, 32'h10, 32'hDEAD_BEEF, 1, 0, "w1_wr10", rd, er);
    check("w1_wr10 dout", rd, 32'h0);
    check("w1_wr10 err", 32'(er), 32'd0);
    access(0, 4'b1111, 32'h10, 32'h0, 1, 0, "w1_rd10", rd, er);
    check("w1_rd10 dout", rd, 32'hDEAD_BEEF);
    check("w1_rd10 err", 32'(er), 32'd0);
    access(0, 4'b1101, 32'h10, 32'h0000_AA00, 1, 0, "w1_lane1", rd, er);
    check("w1_lane1 dout_hold", rd, 32'hDEAD_BEEF);
    access(0, 4'b1111, 32'h11, 32'h0, 1, 0, "w1_rd11", rd, er);
    check("w1_rd11 dout", rd, 32'h00DE_ADAA);
    access(0, 4'b1111, 32'h13, 32'h0, 1, 0, "w1_rd13", rd, er);
    check("w1_rd13 dout", rd, 32'h0000_00DE);
    access(0, 4'b0000, 32'h00, 32'h1234_5678, 1, 0, "w1_wr00", rd, er);
    access(0, 4'b0000, 32'h3C, 32'hA5A5_A5A5, 1, 0, "w1_wr3c", rd, er);
    check("w1_wr3c err", 32'(er), 32'd0);
    access(0, 4'b0000, 32'h40, 32'hFFFF_FFFF, 1, 0, "w1_oor", rd, er);
    check("w1_oor dout", rd, 32'h0);
    check("w1_oor err", 32'(er), 32'd1);
    @(negedge clk);
    check("w1_oor err_pulse", 32'(err_s[0]), 32'd0);
    @(posedge clk); #1;
    access(0, 4'b1111, 32'h00, 32'h0, 1, 0, "w1_rd00", rd, er);
    check("w1_rd00 dout", rd, 32'h1234_5678);
    check("w1_rd00 err", 32'(er), 32'd0);
    access(0, 4'b1111, 32'h3C, 32'h0, 1, 0, "w1_rd3c", rd, er);
    check("w1_rd3c dout", rd, 32'hA5A5_A5A5);
    access(0, 4'b1111, 32'h10, 32'h0, 1, 1, "w1_drop", rd, er);
    check("w1_drop dout", rd, 32'hDEAD_AAEF);
    check("w1_drop err", 32'(er), 32'd0);
    access(0, 4'b1111, 32'hFFFF_FFF0, 32'h0, 1, 0, "w1_oor_rd", rd, er);
    check("w1_oor_rd dout", rd, 32'h0);
    check("w1_oor_rd err", 32'(er), 32'd1);

    // WAIT_CYCLES = 0, back-to-back reads with cs held through DONE
    exp_v[0] = 32'h1111_0001; exp_v[1] = 32'h2222_0002; exp_v[2] = 32'h3333_0003;
    for (int i = 0; i < 3; i++) begin
      access(1, 4'b0000, 32'(4 * (i + 1)), exp_v[i], 0, 0, "w0_wr", rd, er);
    end
    for (int i = 0; i < 3; i++) begin
      cs_d[1] = 1'b1; web_d[1] = 4'hF; addr_d[1] = 32'(4 * (i + 1));
      @(negedge clk);
      check("w0_b2b stall_idle", 32'(stall_s[1]), 32'd1);
      @(posedge clk); #1;
      if (i == 2) cs_d[1] = 1'b0;
      @(negedge clk);
      check("w0_b2b stall_done", 32'(stall_s[1]), 32'd0);
      check("w0_b2b dout", dout_s[1], exp_v[i]);
      check("w0_b2b err", 32'(err_s[1]), 32'd0);
      @(posedge clk); #1;
    end

    // WAIT_CYCLES = 3, reset abandons a pending write
    access(2, 4'b0000, 32'h14, 32'hCAFE_F00D, 3, 0, "w3_wr14", rd, er);
    access(2, 4'b1111, 32'h14, 32'h0, 3, 0, "w3_rd14", rd, er);
    check("w3_rd14 dout", rd, 32'hCAFE_F00D);
    cs_d[2] = 1'b1; web_d[2] = 4'b0000; addr_d[2] = 32'h14; din_d[2] = 32'h1111_1111;
    @(negedge clk);
    check("w3_abort stall0", 32'(stall_s[2]), 32'd1);
    @(posedge clk); #1;
    cs_d[2] = 1'b0;
    @(negedge clk);
    check("w3_abort stall1", 32'(stall_s[2]), 32'd1);
    @(posedge clk); #1;
    rst_d[2] = 1'b1;
    #1;
    check("w3_abort stall", 32'(stall_s[2]), 32'd0);
    check("w3_abort dout", dout_s[2], 32'h0);
    check("w3_abort err", 32'(err_s[2]), 32'd0);
    @(posedge clk); #1;
    rst_d[2] = 1'b0;
    access(2, 4'b1111, 32'h14, 32'h0, 3, 0, "w3_rdback", rd, er);
    check("w3_rdback dout", rd, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
